rx_frame_buf: RTL and testbench

Receive-side frame buffer directly downstream of the RGMII byte receiver. It consumes the receiver's byte stream (`din`, `addr`, where `addr` is the frame byte count minus the 26-byte preamble/header offset, 14-bit wrap) together with `rxctl`, and stores each frame's payload into one of two ping-pong banks. Frames that are too short, too long or arrive with no free bank are dropped and counted. Committed frames are presented to the consumer with a valid/done handshake and a random-access read port.

---
 rtl/rx_frame_buf_pkg.sv | 16 +
 rtl/rx_frame_buf_if.sv | 28 ++
 rtl/rx_frame_buf_dp_ram.sv | 26 ++
 rtl/rx_frame_buf.sv | 141 ++++++++++++++
 tb/tb_rx_frame_buf.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_buf_pkg.sv
// Shared types and constants for the receive-side ping-pong frame buffer.
package rx_pkg;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned HDR_LEN  = 26;
  localparam int unsigned HDR_BASE = (1 << ADDR_W) - HDR_LEN;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] len;
  } frm_desc_t;

endpackage

// File: rtl/rx_frame_buf_if.sv
// Receiver byte stream plus consumer frame handshake and read port.
interface rx_frame_buf_if #(parameter int unsigned DEPTH = 2048);
  import rx_pkg::*;

  localparam int unsigned RA_W = $clog2(DEPTH);

  logic              rxctl;
  logic [7:0]        din;
  logic [ADDR_W-1:0] addr;
  logic [RA_W-1:0]   rd_addr;
  logic [7:0]        rd_data;
  logic              frm_valid;
  logic [ADDR_W-1:0] frm_len;
  logic              frm_bank;
  logic              frm_done;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output rxctl, din, addr, rd_addr, frm_done,
    input  rd_data, frm_valid, frm_len, frm_bank, drop_cnt
  );

  modport slave (
    input  rxctl, din, addr, rd_addr, frm_done,
    output rd_data, frm_valid, frm_len, frm_bank, drop_cnt
  );

endinterface

// File: rtl/rx_frame_buf_dp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module dp_ram #(
  parameter int unsigned WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic [$clog2(WORDS)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Array contents are left unreset; only the read register is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 8'h00;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_frame_buf.sv
// Ping-pong frame buffer: stores validated receive frames into two banks and
// presents them oldest-first to the consumer; rejected frames are counted.
module rx_frame_buf
  import rx_pkg::*;
#(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned MIN_LEN = 46
) (
  input  logic          rxclk,
  input  logic          rst,
  rx_frame_buf_if.slave bus
);

  localparam int unsigned RA_W = $clog2(DEPTH);

  wr_state_t         state, state_nx;
  logic              dv;
  logic              armed;
  logic              wr_bank;
  logic [1:0]        bank_full;
  logic [ADDR_W-1:0] len;
  logic              ovf;
  frm_desc_t         head, tail, push_desc;
  logic              head_vld, tail_vld;
  logic [CNT_W-1:0]  drop_cnt;

  logic in_pay_c, in_hdr_c, we_c, push_c, drop_c, pop_c;

  assign in_pay_c  = bus.addr <  ADDR_W'(DEPTH);
  assign in_hdr_c  = bus.addr >= ADDR_W'(HDR_BASE);
  assign pop_c     = bus.frm_done & head_vld;
  assign push_desc = '{bank: wr_bank, len: len};

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dv    <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      dv    <= bus.rxctl;
      // A start is only recognised once rxctl has been seen low after reset.
      armed <= armed | ~bus.rxctl;
    end
  end

  always_comb begin
    state_nx = state;
    we_c     = 1'b0;
    push_c   = 1'b0;
    drop_c   = 1'b0;
    case (state)
      IDLE: if (dv && armed) state_nx = bank_full[wr_bank] ? DROP : FILL;
      FILL: begin
        if (!dv) begin
          state_nx = IDLE;
          if (len >= ADDR_W'(MIN_LEN) && !ovf) push_c = 1'b1;
          else                                 drop_c = 1'b1;
        end else if (in_pay_c) begin
          we_c = 1'b1;
        end
      end
      DROP: if (!dv) begin
        state_nx = IDLE;
        drop_c   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Length / overflow tracking for the frame being filled.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (state == FILL && dv) begin
      if (in_pay_c && (bus.addr + ADDR_W'(1)) > len) len <= bus.addr + ADDR_W'(1);
      if (!in_pay_c && !in_hdr_c) ovf <= 1'b1;
    end
  end

  // Bank ownership and the two-entry commit FIFO (head + tail registers).
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      bank_full <= 2'b00;
      head_vld  <= 1'b0;
      tail_vld  <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      if (pop_c)  bank_full[head.bank] <= 1'b0;
      if (push_c) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= ~wr_bank;
      end
      if (pop_c) begin
        if (tail_vld) begin
          head     <= tail;
          tail_vld <= push_c;
          if (push_c) tail <= push_desc;
        end else begin
          head_vld <= push_c;
          if (push_c) head <= push_desc;
        end
      end else if (push_c) begin
        if (!head_vld) begin
          head_vld <= 1'b1;
          head     <= push_desc;
        end else begin
          tail_vld <= 1'b1;
          tail     <= push_desc;
        end
      end
    end
  end

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst)                            drop_cnt <= '0;
    else if (drop_c && drop_cnt != '1)  drop_cnt <= drop_cnt + CNT_W'(1);
  end

  assign bus.frm_valid = head_vld;
  assign bus.frm_len   = head.len;
  assign bus.frm_bank  = head.bank;
  assign bus.drop_cnt  = drop_cnt;

  dp_ram #(.WORDS(2 * DEPTH)) u_ram (
    .clk   (rxclk),
    .rst   (rst),
    .we    (we_c),
    .waddr ({wr_bank, bus.addr[RA_W-1:0]}),
    .wdata (bus.din),
    .raddr ({head.bank, bus.rd_addr}),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_rx_frame_buf.sv
// Directed bench for rx_frame_buf: table of frame vectors plus corner sequences.
module tb_rx_frame_buf;
  import rx_pkg::*;

  localparam int unsigned DEPTH = 2048;

  logic rxclk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 rxclk = ~rxclk;

  rx_frame_buf_if #(.DEPTH(DEPTH)) bus ();

  rx_frame_buf #(.DEPTH(DEPTH), .MIN_LEN(46)) dut (
    .rxclk (rxclk),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int plen;
    bit done;
    bit v;
    int len;
    bit bank;
    int drop;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge rxclk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.rxctl     = 1'b0;
    bus.din       = 8'h00;
    bus.addr      = '0;
    bus.rd_addr   = '0;
    bus.frm_done  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Drives one byte of a frame stream: header bytes first, then payload 0..
  task automatic drive_byte(input int i);
    logic [13:0] a;
    a        = (i < int'(HDR_LEN)) ? 14'(int'(HDR_BASE) + i) : 14'(i - int'(HDR_LEN));
    bus.addr = a;
    bus.din  = a[7:0];
  endtask

  // rxctl leads the byte stream by one cycle; returns at the start of the
  // cycle in which the DUT sees dv fall (the commit cycle).
  task automatic stream(input int plen);
    int n;
    n = int'(HDR_LEN) + plen;
    bus.rxctl = 1'b1;
    cyc();
    for (int i = 0; i < n; i++) begin
      drive_byte(i);
      bus.rxctl = (i < n - 1);
      cyc();
    end
  endtask

  task automatic pulse_done();
    bus.frm_done = 1'b1;
    cyc();
    bus.frm_done = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{20,   0, 0, 0,    0, 1};
    tbl[1]  = '{64,   0, 1, 64,   0, 1};
    tbl[2]  = '{64,   0, 1, 64,   0, 1};
    tbl[3]  = '{64,   0, 1, 64,   0, 2};
    tbl[4]  = '{0,    1, 1, 64,   1, 2};
    tbl[5]  = '{100,  0, 1, 64,   1, 2};
    tbl[6]  = '{0,    1, 1, 100,  0, 2};
    tbl[7]  = '{0,    1, 0, 0,    0, 2};
    tbl[8]  = '{46,   0, 1, 46,   1, 2};
    tbl[9]  = '{45,   1, 0, 0,    0, 3};
    tbl[10] = '{2049, 1, 0, 0,    0, 4};
    tbl[11] = '{2048, 0, 1, 2048, 0, 4};

    // Reset values and basic 64-byte frame with read-back.
    do_reset();
    check("rst_valid",   int'(bus.frm_valid), 0);
    check("rst_len",     int'(bus.frm_len),   0);
    check("rst_bank",    int'(bus.frm_bank),  0);
    check("rst_drop",    int'(bus.drop_cnt),  0);
    check("rst_rd_data", int'(bus.rd_data),   0);
    stream(64);
    check("pre_commit_valid", int'(bus.frm_valid), 0);
    cyc();
    check("f64_valid", int'(bus.frm_valid), 1);
    check("f64_len",   int'(bus.frm_len),   64);
    check("f64_bank",  int'(bus.frm_bank),  0);
    bus.rd_addr = 11'd5;
    cyc();
    check("rd_5", int'(bus.rd_data), 5);
    bus.rd_addr = 11'd63;
    cyc();
    check("rd_63", int'(bus.rd_data), 63);
    bus.rd_addr = 11'd0;
    cyc();
    check("rd_0", int'(bus.rd_data), 0);

    // Table-driven frame sequence from a clean reset.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].done) pulse_done();
      if (tbl[i].plen > 0) begin
        stream(tbl[i].plen);
        cyc();
        cyc();
      end
      check($sformatf("row%0d_valid", i), int'(bus.frm_valid), int'(tbl[i].v));
      check($sformatf("row%0d_drop", i),  int'(bus.drop_cnt),  tbl[i].drop);
      if (tbl[i].v) begin
        check($sformatf("row%0d_len", i),  int'(bus.frm_len),  tbl[i].len);
        check($sformatf("row%0d_bank", i), int'(bus.frm_bank), int'(tbl[i].bank));
      end
    end

    // Commit of bank 1 in the same cycle as release of bank 0.
    do_reset();
    stream(64);
    cyc();
    cyc();
    stream(80);
    pulse_done();
    check("same_valid", int'(bus.frm_valid), 1);
    check("same_bank",  int'(bus.frm_bank),  1);
    check("same_len",   int'(bus.frm_len),   80);
    cyc();
    stream(50);
    cyc();
    cyc();
    check("same_hold_bank", int'(bus.frm_bank), 1);
    check("same_drop",      int'(bus.drop_cnt), 0);
    pulse_done();
    check("same_next_bank", int'(bus.frm_bank), 0);
    check("same_next_len",  int'(bus.frm_len),  50);

    // Reset asserted at payload byte 30 with rxctl held high across release.
    do_reset();
    bus.rd_addr = 11'd10;
    bus.rxctl   = 1'b1;
    cyc();
    for (int i = 0; i < int'(HDR_LEN) + 30; i++) begin
      drive_byte(i);
      cyc();
    end
    rst = 1'b1;
    #1;
    check("mid_rst_valid",   int'(bus.frm_valid), 0);
    check("mid_rst_len",     int'(bus.frm_len),   0);
    check("mid_rst_drop",    int'(bus.drop_cnt),  0);
    check("mid_rst_rd_data", int'(bus.rd_data),   0);
    cyc();
    rst = 1'b0;
    for (int i = int'(HDR_LEN) + 30; i < int'(HDR_LEN) + 64; i++) begin
      drive_byte(i);
      cyc();
    end
    bus.rxctl = 1'b0;
    cyc();
    cyc();
    cyc();
    check("mid_after_valid", int'(bus.frm_valid), 0);
    check("mid_after_drop",  int'(bus.drop_cnt),  0);
    stream(64);
    cyc();
    check("mid_next_valid", int'(bus.frm_valid), 1);
    check("mid_next_bank",  int'(bus.frm_bank),  0);
    check("mid_next_len",   int'(bus.frm_len),   64);
    check("mid_next_drop",  int'(bus.drop_cnt),  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
